// File: rtl/alu_seq.sv
// alu_seq: issue controller that sequences the shared 32-bit ALU one
// data-processing op at a time. It gates each op on its ARM condition code,
// owns the CPSR flags (bit0 Z, bit1 C, bit2 N, bit3 V), derives C and V
// itself, and runs ADC/SBC/RSC as two ALU passes.
module alu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_code,
  input  logic [31:0] req_rn,
  input  logic [31:0] req_shifter,
  input  logic [3:0]  req_cond,
  input  logic        req_setflags,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_out,
  output logic        resp_wb,
  output logic [3:0]  alu_code,
  output logic [31:0] alu_rn,
  output logic [31:0] alu_shifter,
  input  logic [31:0] alu_out,
  output logic [3:0]  flags
);

  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_RSB  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_ADC  = 4'b0101;
  localparam logic [3:0] OP_SBC  = 4'b0110;
  localparam logic [3:0] OP_RSC  = 4'b0111;
  localparam logic [3:0] OP_CMP  = 4'b1010;
  localparam logic [3:0] OP_CMN  = 4'b1011;
  localparam logic [3:0] OP_PASS = 4'b1101;

  typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  op_code;
  logic [31:0] op_rn;
  logic [31:0] op_sh;
  logic [3:0]  op_cond;
  logic        op_s;
  logic        cin;
  logic [31:0] tmp;
  logic        c1;

  logic        cond_ok;
  logic [3:0]  pass1_code;
  logic        two_pass;
  logic        is_add;
  logic        is_sub;
  logic        is_rev;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        c_p1;
  logic        c_p2;
  logic        c_fin;
  logic        v_fin;
  logic [3:0]  flags_nxt;
  logic        finish;
  logic        flag_we;

  // State register; reset returns to IDLE from anywhere, including mid-op.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Evaluate the latched ARM condition field against the current flags.
  always_comb begin
    cond_ok = 1'b0;
    case (op_cond)
      4'b0000: cond_ok = flags[0];
      4'b0001: cond_ok = ~flags[0];
      4'b0010: cond_ok = flags[1];
      4'b0011: cond_ok = ~flags[1];
      4'b0100: cond_ok = flags[2];
      4'b0101: cond_ok = ~flags[2];
      4'b0110: cond_ok = flags[3];
      4'b0111: cond_ok = ~flags[3];
      4'b1000: cond_ok = flags[1] & ~flags[0];
      4'b1001: cond_ok = ~flags[1] | flags[0];
      4'b1010: cond_ok = (flags[2] == flags[3]);
      4'b1011: cond_ok = (flags[2] != flags[3]);
      4'b1100: cond_ok = ~flags[0] & (flags[2] == flags[3]);
      4'b1101: cond_ok = flags[0] | (flags[2] != flags[3]);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Classify the op and map the carry-using ops onto what the ALU supports.
  always_comb begin
    pass1_code = op_code;
    case (op_code)
      OP_ADC:  pass1_code = OP_ADD;
      OP_SBC:  pass1_code = OP_SUB;
      OP_RSC:  pass1_code = OP_RSB;
      default: pass1_code = op_code;
    endcase
    two_pass = (op_code == OP_ADC) | (op_code == OP_SBC) | (op_code == OP_RSC);
    is_add   = (op_code == OP_ADD) | (op_code == OP_ADC) | (op_code == OP_CMN);
    is_rev   = (op_code == OP_RSB) | (op_code == OP_RSC);
    is_sub   = (op_code == OP_SUB) | (op_code == OP_SBC) | (op_code == OP_CMP) | is_rev;
    opa      = is_rev ? op_sh : op_rn;
    opb      = is_rev ? op_rn : op_sh;
  end

  // Next state, request handshake and ALU operand steering.
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    alu_code    = OP_PASS;
    alu_rn      = 32'd0;
    alu_shifter = 32'd0;
    case (state)
      IDLE: begin
        req_ready = ~reset;
        if (req_valid) state_nxt = EXEC1;
      end
      EXEC1: begin
        alu_code    = pass1_code;
        alu_rn      = op_rn;
        alu_shifter = op_sh;
        if (cond_ok && two_pass) state_nxt = EXEC2;
        else                     state_nxt = DONE;
      end
      EXEC2: begin
        alu_code    = (op_code == OP_ADC) ? OP_ADD : OP_SUB;
        alu_rn      = tmp;
        alu_shifter = {31'd0, (op_code == OP_ADC) ? cin : ~cin};
        state_nxt   = DONE;
      end
      DONE: begin
        if (resp_valid && resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Derive per-pass carries, the final C/V and the candidate flag value.
  always_comb begin
    c_p1 = is_add ? ((opa[31] & opb[31]) | ((opa[31] | opb[31]) & ~alu_out[31]))
                  : (opa >= opb);
    c_p2 = is_add ? ((tmp[31] & alu_shifter[31]) | ((tmp[31] | alu_shifter[31]) & ~alu_out[31]))
                  : (tmp >= alu_shifter);
    if (state == EXEC2) c_fin = is_add ? (c1 | c_p2) : (c1 & c_p2);
    else                c_fin = c_p1;
    v_fin = is_add ? ((opa[31] == opb[31]) & (alu_out[31] != opa[31]))
                   : ((opa[31] != opb[31]) & (alu_out[31] != opa[31]));
    flags_nxt[0] = (alu_out == 32'd0);
    flags_nxt[1] = (is_add | is_sub) ? c_fin : flags[1];
    flags_nxt[2] = alu_out[31];
    flags_nxt[3] = (is_add | is_sub) ? v_fin : flags[3];
    finish  = ((state == EXEC1) & cond_ok & ~two_pass) | (state == EXEC2);
    flag_we = finish & (op_s | (op_code[3:2] == 2'b10));
  end

  // Operand latch, pass-1 capture, response registers and flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags      <= 4'd0;
      resp_valid <= 1'b0;
      resp_out   <= 32'd0;
      resp_wb    <= 1'b0;
      op_code    <= 4'd0;
      op_rn      <= 32'd0;
      op_sh      <= 32'd0;
      op_cond    <= 4'd0;
      op_s       <= 1'b0;
      cin        <= 1'b0;
      tmp        <= 32'd0;
      c1         <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        op_code <= req_code;
        op_rn   <= req_rn;
        op_sh   <= req_shifter;
        op_cond <= req_cond;
        op_s    <= req_setflags;
        cin     <= flags[1];
      end
      if (state == EXEC1) begin
        tmp <= alu_out;
        c1  <= c_p1;
        if (!cond_ok) begin
          resp_out <= 32'd0;
          resp_wb  <= 1'b0;
        end
      end
      if (finish) begin
        resp_out <= alu_out;
        resp_wb  <= (op_code[3:2] != 2'b10);
      end
      if (flag_we) flags <= flags_nxt;
      if (state == DONE) resp_valid <= ~(resp_valid & resp_ready);
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq. A model of the shared ALU sits
// on the alu_* ports; a driver issues directed then random ops and queues
// the architecturally expected result, and a monitor checks each response.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_code;
  logic [31:0] req_rn;
  logic [31:0] req_shifter;
  logic [3:0]  req_cond;
  logic        req_setflags;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_out;
  logic        resp_wb;
  logic [3:0]  alu_code;
  logic [31:0] alu_rn;
  logic [31:0] alu_shifter;
  logic [31:0] alu_out;
  logic [3:0]  flags;

  typedef struct {
    logic [31:0] out;
    logic        wb;
    logic [3:0]  fl;
    int          issue;
    int          lat;
  } exp_t;

  exp_t        expq[$];
  exp_t        cur;
  int          total = 0;
  int          bad = 0;
  int          pcount = 0;
  int          hold_low = 0;
  bit          rand_ready = 1'b0;
  bit          seen = 1'b0;
  logic [3:0]  mflags = 4'd0;
  logic [3:0]  r_code;
  logic [31:0] r_rn;
  logic [31:0] r_sh;
  logic [3:0]  r_cond;
  logic        r_s;

  always #5 clk = ~clk;

  always @(posedge clk) pcount <= pcount + 1;

  alu_seq dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_code(req_code),
    .req_rn(req_rn), .req_shifter(req_shifter), .req_cond(req_cond),
    .req_setflags(req_setflags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_out(resp_out),
    .resp_wb(resp_wb),
    .alu_code(alu_code), .alu_rn(alu_rn), .alu_shifter(alu_shifter),
    .alu_out(alu_out), .flags(flags)
  );

  // Shared ALU: no carry-in ops, no flags; unsupported codes give 0.
  always_comb begin
    alu_out = 32'd0;
    case (alu_code)
      4'b0000, 4'b1000: alu_out = alu_rn & alu_shifter;
      4'b0001, 4'b1001: alu_out = alu_rn ^ alu_shifter;
      4'b0010, 4'b1010: alu_out = alu_rn - alu_shifter;
      4'b0011:          alu_out = alu_shifter - alu_rn;
      4'b0100, 4'b1011: alu_out = alu_rn + alu_shifter;
      4'b1100:          alu_out = alu_rn | alu_shifter;
      4'b1101:          alu_out = alu_shifter;
      4'b1110:          alu_out = alu_rn & ~alu_shifter;
      4'b1111:          alu_out = ~alu_shifter;
      default:          alu_out = 32'd0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic condHolds(input logic [3:0] cond, input logic [3:0] f);
    logic z, c, n, v;
    z = f[0]; c = f[1]; n = f[2]; v = f[3];
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Architectural ARM result: full-width sums with carry-in, not passes.
  function automatic void refModel(input logic [3:0] code, input logic [31:0] rn,
                                   input logic [31:0] sh, input logic [3:0] cond,
                                   input logic s, input logic [3:0] fin,
                                   output logic [31:0] r, output logic wb,
                                   output logic [3:0] fout);
    logic [32:0] wide;
    logic        c, v, ci;
    fout = fin;
    if (!condHolds(cond, fin)) begin
      r = 32'd0; wb = 1'b0;
      return;
    end
    c = fin[1]; v = fin[3]; ci = fin[1];
    r = 32'd0;
    case (code)
      4'b0000, 4'b1000: r = rn & sh;
      4'b0001, 4'b1001: r = rn ^ sh;
      4'b1100: r = rn | sh;
      4'b1101: r = sh;
      4'b1110: r = rn & ~sh;
      4'b1111: r = ~sh;
      4'b0010, 4'b1010: begin
        r = rn - sh; c = (rn >= sh); v = (rn[31] != sh[31]) && (r[31] != rn[31]);
      end
      4'b0011: begin
        r = sh - rn; c = (sh >= rn); v = (sh[31] != rn[31]) && (r[31] != sh[31]);
      end
      4'b0100, 4'b1011: begin
        wide = {1'b0, rn} + {1'b0, sh};
        r = wide[31:0]; c = wide[32]; v = (rn[31] == sh[31]) && (r[31] != rn[31]);
      end
      4'b0101: begin
        wide = {1'b0, rn} + {1'b0, sh} + {32'd0, ci};
        r = wide[31:0]; c = wide[32]; v = (rn[31] == sh[31]) && (r[31] != rn[31]);
      end
      4'b0110: begin
        r = rn - sh - {31'd0, !ci};
        c = ({1'b0, rn} >= ({1'b0, sh} + {32'd0, !ci}));
        v = (rn[31] != sh[31]) && (r[31] != rn[31]);
      end
      default: begin
        r = sh - rn - {31'd0, !ci};
        c = ({1'b0, sh} >= ({1'b0, rn} + {32'd0, !ci}));
        v = (sh[31] != rn[31]) && (r[31] != sh[31]);
      end
    endcase
    wb = (code[3:2] != 2'b10);
    if (s || code[3:2] == 2'b10) fout = {v, r[31], c, (r == 32'd0)};
  endfunction

  // Issue one op when the DUT is idle and queue its expected response.
  task automatic applyStimulus(input logic [3:0] code, input logic [31:0] rn,
                               input logic [31:0] sh, input logic [3:0] cond,
                               input logic s);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("[TB] FAIL accept_timeout got req_ready=0 want 1 within 100 cycles");
      return;
    end
    req_code = code; req_rn = rn; req_shifter = sh; req_cond = cond; req_setflags = s;
    req_valid = 1'b1;
    refModel(code, rn, sh, cond, s, mflags, e.out, e.wb, e.fl);
    e.issue = pcount;
    e.lat   = (condHolds(cond, mflags) && (code == 4'b0101 || code == 4'b0110 || code == 4'b0111)) ? 4 : 3;
    mflags  = e.fl;
    expq.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_code = 4'($urandom); req_rn = $urandom; req_shifter = $urandom;
    req_cond = 4'($urandom); req_setflags = 1'($urandom);
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((!req_ready || resp_valid || expq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("[TB] FAIL idle_timeout got busy want idle within 200 cycles");
    end
  endtask

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: drive resp_ready, then check each response against the queue.
  always @(negedge clk) begin
    if (reset) begin
      seen = 1'b0;
    end else begin
      if (resp_valid && hold_low > 0) begin
        resp_ready = 1'b0;
        hold_low--;
      end else if (rand_ready) begin
        resp_ready = ($urandom_range(0, 2) != 0);
      end else begin
        resp_ready = 1'b1;
      end
      if (resp_valid) begin
        checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
        if (!seen) begin
          if (expq.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL unexpected_resp got out=%h want no response", resp_out);
          end else begin
            cur = expq.pop_front();
            checkOutput("resp_out", resp_out, cur.out);
            checkOutput("resp_wb", 32'(resp_wb), 32'(cur.wb));
            checkOutput("resp_flags", 32'(flags), 32'(cur.fl));
            checkOutput("latency", 32'(pcount - cur.issue), 32'(cur.lat));
          end
          seen = 1'b1;
        end else begin
          checkOutput("hold_out", resp_out, cur.out);
          checkOutput("hold_wb", 32'(resp_wb), 32'(cur.wb));
        end
        if (resp_ready) seen = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got no finish want finish before 20000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
    req_code = 4'd0; req_rn = 32'd0; req_shifter = 32'd0; req_cond = 4'd0; req_setflags = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready_low", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_flags", 32'(flags), 32'd0);
    checkOutput("reset_resp_out", resp_out, 32'd0);
    checkOutput("reset_resp_wb", 32'(resp_wb), 32'd0);

    applyStimulus(4'b0100, 32'hFFFF_FFFF, 32'h1, 4'b1110, 1'b1);
    waitIdle();
    checkOutput("flags_add_wrap", 32'(flags), 32'h3);

    applyStimulus(4'b0101, 32'd5, 32'd7, 4'b1110, 1'b1);
    @(negedge clk);
    checkOutput("adc_exec2_code", 32'(alu_code), 32'h4);
    checkOutput("adc_exec2_rn", alu_rn, 32'hC);
    checkOutput("adc_exec2_shifter", alu_shifter, 32'h1);
    waitIdle();
    checkOutput("flags_adc", 32'(flags), 32'h0);

    applyStimulus(4'b0110, 32'd10, 32'd3, 4'b1110, 1'b1);
    waitIdle();
    checkOutput("flags_sbc", 32'(flags), 32'h2);

    applyStimulus(4'b1010, 32'd3, 32'd5, 4'b1110, 1'b0);
    waitIdle();
    checkOutput("flags_cmp", 32'(flags), 32'h4);

    applyStimulus(4'b0111, 32'd3, 32'd10, 4'b1110, 1'b0);
    waitIdle();
    checkOutput("flags_rsc_kept", 32'(flags), 32'h4);

    applyStimulus(4'b1101, 32'd0, 32'h55, 4'b0000, 1'b1);
    waitIdle();
    checkOutput("flags_moveq_kept", 32'(flags), 32'h4);

    hold_low = 3;
    applyStimulus(4'b0100, 32'h7FFF_FFFF, 32'h1, 4'b1110, 1'b1);
    waitIdle();
    checkOutput("flags_overflow", 32'(flags), 32'hC);

    applyStimulus(4'b0101, 32'd1, 32'd2, 4'b1110, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midop_req_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    expq.delete();
    mflags = 4'd0;
    #1;
    checkOutput("midop_req_ready", 32'(req_ready), 32'd1);
    checkOutput("midop_flags", 32'(flags), 32'd0);
    checkOutput("midop_resp_valid", 32'(resp_valid), 32'd0);

    applyStimulus(4'b0100, 32'd2, 32'd3, 4'b1110, 1'b1);
    waitIdle();
    checkOutput("flags_after_reset_add", 32'(flags), 32'h0);

    rand_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      r_code = 4'($urandom_range(0, 15));
      r_rn   = pickVal();
      r_sh   = pickVal();
      r_cond = ($urandom_range(0, 9) < 6) ? 4'b1110 : 4'($urandom_range(0, 15));
      r_s    = 1'($urandom);
      applyStimulus(r_code, r_rn, r_sh, r_cond, r_s);
    end
    waitIdle();
    checkOutput("queue_drained", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
